// File: rtl/video_sync_gen.sv
// Horizontal/vertical timing generator: pixel-rate counters, registered blank/pixel/sync decodes
// and line/frame strobes. Define VSG_FRAME_INT_EN to build the Z80 frame interrupt (int_n).
module video_sync_gen #(
    parameter int H_TOTAL    = 448,
    parameter int H_SYNC_BEG = 8,
    parameter int H_SYNC_END = 40,
    parameter int H_BLNK_END = 88,
    parameter int H_PIX_BEG  = 104,
    parameter int H_PIX_END  = 360,
    parameter int VGA_HS_LEN = 27,
    parameter int V_TOTAL    = 320,
    parameter int V_SYNC_BEG = 2,
    parameter int V_SYNC_END = 4,
    parameter int V_BLNK_END = 16,
    parameter int V_PIX_BEG  = 80,
    parameter int V_PIX_END  = 272,
    parameter int INT_V      = 0,
    parameter int INT_H      = 0,
    parameter int INT_LEN    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       hblank,
    output logic       vblank,
    output logic       hpix,
    output logic       vpix,
    output logic       hsync,
    output logic       vsync,
    output logic       vga_hsync,
    output logic       line_start,
    output logic       frame_start,
    output logic       int_n
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] HS_BEG   = 9'(H_SYNC_BEG);
    localparam logic [8:0] HS_END   = 9'(H_SYNC_END);
    localparam logic [8:0] HB_END   = 9'(H_BLNK_END);
    localparam logic [8:0] HP_BEG   = 9'(H_PIX_BEG);
    localparam logic [8:0] HP_END   = 9'(H_PIX_END);
    localparam logic [8:0] VS_BEG   = 9'(V_SYNC_BEG);
    localparam logic [8:0] VS_END   = 9'(V_SYNC_END);
    localparam logic [8:0] VB_END   = 9'(V_BLNK_END);
    localparam logic [8:0] VP_BEG   = 9'(V_PIX_BEG);
    localparam logic [8:0] VP_END   = 9'(V_PIX_END);
    // Scan-doubled VGA line sync: one pulse at each half of the TV line.
    localparam logic [8:0] VGA1_END = 9'(VGA_HS_LEN);
    localparam logic [8:0] VGA2_BEG = 9'(H_TOTAL / 2);
    localparam logic [8:0] VGA2_END = 9'(H_TOTAL / 2 + VGA_HS_LEN);

    logic       h_wrap;
    logic       v_wrap;
    logic [8:0] h_next;
    logic [8:0] v_next;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_next = h_wrap ? 9'd0 : hcount + 9'd1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 9'd0 : vcount + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= 9'd0;
            vcount <= 9'd0;
        end else if (ce) begin
            hcount <= h_next;
            vcount <= v_next;
        end
    end

    // Decodes are refreshed every clk from the current counters, so they trail them by one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            hpix        <= 1'b0;
            vpix        <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            vga_hsync   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hblank      <= (hcount < HB_END);
            vblank      <= (vcount < VB_END);
            hpix        <= (hcount >= HP_BEG) && (hcount < HP_END);
            vpix        <= (vcount >= VP_BEG) && (vcount < VP_END);
            hsync       <= (hcount >= HS_BEG) && (hcount < HS_END);
            vsync       <= (vcount >= VS_BEG) && (vcount < VS_END);
            vga_hsync   <= (hcount < VGA1_END) ||
                           ((hcount >= VGA2_BEG) && (hcount < VGA2_END));
            line_start  <= ce && h_wrap;
            frame_start <= ce && h_wrap && v_wrap;
        end
    end

`ifdef VSG_FRAME_INT_EN
    localparam logic [8:0] INT_V9   = 9'(INT_V);
    localparam logic [8:0] INT_H9   = 9'(INT_H);
    localparam logic [5:0] INT_LEN6 = 6'(INT_LEN);

    logic [5:0] int_cnt;

    // Counter reaches zero on the INT_LEN-th ce tick after the trigger, releasing int_n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_cnt <= 6'd0;
            int_n   <= 1'b1;
        end else if (ce) begin
            if ((v_next == INT_V9) && (h_next == INT_H9)) begin
                int_cnt <= INT_LEN6;
                int_n   <= 1'b0;
            end else if (int_cnt != 6'd0) begin
                int_cnt <= int_cnt - 6'd1;
                if (int_cnt == 6'd1) begin
                    int_n <= 1'b1;
                end
            end
        end
    end
`else
    assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen; vertical timing is shortened (24-line frame) to keep runtime small.
module tb_video_sync_gen;

    localparam int VT = 24;
    localparam int HT = 448;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [8:0] hcount, vcount;
    logic       hblank, vblank, hpix, vpix, hsync, vsync, vga_hsync;
    logic       line_start, frame_start, int_n;

    int n_tests = 0;
    int n_fail  = 0;

    video_sync_gen #(
        .V_TOTAL(VT), .V_SYNC_BEG(2), .V_SYNC_END(4), .V_BLNK_END(6),
        .V_PIX_BEG(8), .V_PIX_END(20)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount(hcount), .vcount(vcount),
        .hblank(hblank), .vblank(vblank), .hpix(hpix), .vpix(vpix),
        .hsync(hsync), .vsync(vsync), .vga_hsync(vga_hsync),
        .line_start(line_start), .frame_start(frame_start), .int_n(int_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int found;
    int hs_cnt, hs_rise, hp_cnt, hb_cnt, vga_cnt, vga_rises, vr1, vr2, ls_cnt, ls_at;
    int fs_cnt, fs_ls, vs_cnt, vp_cnt, vb_cnt, int_lo, hchg;
    int int_exp;
    logic p_hs, p_vga;
    logic [8:0] p_h;

    initial begin
`ifdef VSG_FRAME_INT_EN
        int_exp = 32;
`else
        int_exp = 0;
`endif
        // Power-on reset
        rst = 1'b1;
        ce  = 1'b0;
        repeat (3) step();
        check("rst_hcount", hcount, 0);
        check("rst_hblank", hblank, 0);
        check("rst_int_n", int_n, 1);
        rst = 1'b0;
        ce  = 1'b1;
        step();
        check("rel_hblank", hblank, 1);
        check("rel_vblank", vblank, 1);
        check("rel_hcount", hcount, 1);
        check("rel_hsync", hsync, 0);

        // Line timing over one full line
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            step();
            if (line_start) found = 1;
        end
        check("line_start_seen", found, 1);
        check("ls_hcount", hcount, 0);
        hs_cnt = 0; hs_rise = -1; hp_cnt = 0; hb_cnt = 0; vga_cnt = 0; vga_rises = 0;
        vr1 = -1; vr2 = -1; ls_cnt = 0; ls_at = -1;
        p_hs = hsync; p_vga = vga_hsync;
        for (int i = 1; i <= HT; i++) begin
            step();
            if (hsync) hs_cnt++;
            if (hsync && !p_hs) hs_rise = hcount;
            if (hpix) hp_cnt++;
            if (hblank) hb_cnt++;
            if (vga_hsync) vga_cnt++;
            if (vga_hsync && !p_vga) begin
                vga_rises++;
                if (vga_rises == 1) vr1 = hcount;
                if (vga_rises == 2) vr2 = hcount;
            end
            if (line_start) begin
                ls_cnt++;
                ls_at = i;
            end
            p_hs = hsync; p_vga = vga_hsync;
        end
        check("hsync_width", hs_cnt, 32);
        check("hsync_rise_h", hs_rise, 9);
        check("hpix_width", hp_cnt, 256);
        check("hblank_width", hb_cnt, 88);
        check("vga_total", vga_cnt, 54);
        check("vga_pulses", vga_rises, 2);
        check("vga_rise1_h", vr1, 1);
        check("vga_rise2_h", vr2, 225);
        check("ls_count", ls_cnt, 1);
        check("ls_period", ls_at, HT);

        // Frame wrap
        found = 0;
        for (int i = 0; i < HT * VT + 100 && found == 0; i++) begin
            step();
            if (frame_start) found = 1;
        end
        check("frame_start_seen", found, 1);
        check("fs_ls", line_start, 1);
        check("fs_hcount", hcount, 0);
        check("fs_vcount", vcount, 0);
        fs_cnt = 0; fs_ls = 0; vs_cnt = 0; vp_cnt = 0; vb_cnt = 0; int_lo = 0; ls_cnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            step();
            if (frame_start) begin
                fs_cnt++;
                if (line_start) fs_ls++;
            end
            if (line_start) ls_cnt++;
            if (vsync) vs_cnt++;
            if (vpix) vp_cnt++;
            if (vblank) vb_cnt++;
            if (!int_n) int_lo++;
        end
        check("frame_fs_count", fs_cnt, 1);
        check("frame_fs_with_ls", fs_ls, 1);
        check("frame_ls_count", ls_cnt, VT);
        check("vsync_width", vs_cnt, 2 * HT);
        check("vpix_width", vp_cnt, 12 * HT);
        check("vblank_width", vb_cnt, 6 * HT);
        check("int_low_ticks", int_lo, int_exp);

        // Asynchronous reset mid-frame
        found = 0;
        for (int i = 0; i < 6000 && found == 0; i++) begin
            step();
            if (hcount == 9'd200 && vcount == 9'd10) found = 1;
        end
        check("mid_frame_reached", found, 1);
        check("mid_hpix", hpix, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_hcount", hcount, 0);
        check("arst_vcount", vcount, 0);
        check("arst_outs", {hblank, vblank, hpix, vpix, hsync, vsync, vga_hsync,
                            line_start, frame_start}, 0);
        check("arst_int_n", int_n, 1);
        step();
        step();
        check("arst_hold_hcount", hcount, 0);
        rst = 1'b0;
        ce  = 1'b1;
        step();
        check("arst_rel_hblank", hblank, 1);
        check("arst_rel_vblank", vblank, 1);

        // ce on every second clk
        found = 0;
        for (int i = 0; i < 2 * HT + 100 && found == 0; i++) begin
            step();
            if (line_start) found = 1;
            ce = ~ce;
        end
        check("ce_ls_seen", found, 1);
        hs_cnt = 0; hp_cnt = 0; ls_cnt = 0; hchg = 0;
        p_h = hcount;
        for (int i = 0; i < 2 * HT; i++) begin
            step();
            if (hsync) hs_cnt++;
            if (hpix) hp_cnt++;
            if (line_start) ls_cnt++;
            if (hcount != p_h) hchg++;
            p_h = hcount;
            ce = ~ce;
        end
        check("ce_hsync_width", hs_cnt, 64);
        check("ce_hpix_width", hp_cnt, 512);
        check("ce_ls_count", ls_cnt, 1);
        check("ce_h_advances", hchg, HT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
